// File: rtl/fan_pkg.sv
// Shared constants and helpers for the fan speed monitor.
// Contents:
//   MAX_SPEED_W   - widest speed value the helpers support
//   MAX_FANS      - widest fan select vector the one-hot check accepts
//   STALL_WINDOWS - consecutive zero-speed windows before a fan is flagged as stalled
//   speed_err()   - all-ones error/idle pattern for a given speed width (SPEED_ERR)
//   is_one_hot()  - true when exactly one select bit is set
package fan_pkg;

    localparam int unsigned MAX_SPEED_W   = 32;
    localparam int unsigned MAX_FANS      = 16;
    localparam int unsigned STALL_WINDOWS = 2;

    // All-ones pattern of the requested width, zero-extended to MAX_SPEED_W.
    function automatic logic [MAX_SPEED_W-1:0] speed_err(input int unsigned width);
        logic [MAX_SPEED_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_SPEED_W; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_one_hot(input logic [MAX_FANS-1:0] v);
        return (v != '0) && ((v & (v - MAX_FANS'(1))) == '0);
    endfunction

endpackage

// File: rtl/fan_tach_counter.sv
// One tachometer channel: 2-flop synchroniser, rising-edge detector,
// saturating pulse counter and per-window latched speed.
// Optional feature macro: FAN_STALL_DETECT_EN adds the stall flag.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   tach       - raw asynchronous tachometer input
//   terminal   - high in the last cycle of a measurement window
//   speed      - speed latched at the end of the previous window
//   stall      - (FAN_STALL_DETECT_EN only) latched speed zero for STALL_WINDOWS windows
module fan_tach_counter
    import fan_pkg::*;
#(
    parameter int unsigned SPEED_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tach,
    input  logic               terminal,
    output logic [SPEED_W-1:0] speed
`ifdef FAN_STALL_DETECT_EN
    ,
    output logic               stall
`endif
);

    localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(speed_err(SPEED_W));

    logic               sync1;
    logic               sync2;
    logic               prev;
    logic               pulse_c;
    logic [SPEED_W-1:0] count;
    logic [SPEED_W-1:0] count_next_c;

    // Edge pulse is high for one cycle, three cycles after tach rises.
    assign pulse_c      = sync2 & ~prev;
    assign count_next_c = (pulse_c && (count != SPEED_MAX)) ? count + SPEED_W'(1) : count;

    // Synchroniser, edge history, counter and window latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            count <= '0;
            speed <= '0;
        end else begin
            sync1 <= tach;
            sync2 <= sync1;
            prev  <= sync2;
            if (terminal) begin
                // An edge landing in the terminal cycle still belongs to this window.
                speed <= count_next_c;
                count <= '0;
            end else begin
                count <= count_next_c;
            end
        end
    end

`ifdef FAN_STALL_DETECT_EN
    localparam int unsigned ZW = $clog2(STALL_WINDOWS + 1);

    logic [ZW-1:0] zero_windows;

    // Counts consecutive zero-speed windows, saturating at STALL_WINDOWS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_windows <= '0;
            stall        <= 1'b0;
        end else if (terminal) begin
            if (count_next_c == '0) begin
                if (zero_windows != ZW'(STALL_WINDOWS)) begin
                    zero_windows <= zero_windows + ZW'(1);
                end
                stall <= (zero_windows >= ZW'(STALL_WINDOWS - 1));
            end else begin
                zero_windows <= '0;
                stall        <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/fan_speed_monitor.sv
// Multi-channel fan tachometer monitor. Counts tach pulses per fan over a
// fixed window, latches the counts as speeds, and serves registered reads
// selected by a one-hot fan select.
// Optional feature macro: FAN_STALL_DETECT_EN adds the stall output.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   tach          - asynchronous tach inputs, one per fan
//   fan_selection - one-hot fan select for reads
//   read          - read request, sampled every cycle
//   speed_out     - registered speed (all-ones when idle or on bad select)
//   read_valid    - speed_out holds a reading this cycle
//   sel_error     - last sampled read had a non-one-hot select
//   window_done   - one-cycle pulse when new speeds have been latched
//   stall         - (FAN_STALL_DETECT_EN only) per-fan stall flags
module fan_speed_monitor
    import fan_pkg::*;
#(
    parameter int unsigned NUM_FANS      = 4,
    parameter int unsigned SPEED_W       = 8,
    parameter int unsigned WINDOW_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_FANS-1:0] tach,
    input  logic [NUM_FANS-1:0] fan_selection,
    input  logic                read,
    output logic [SPEED_W-1:0]  speed_out,
    output logic                read_valid,
    output logic                sel_error,
    output logic                window_done
`ifdef FAN_STALL_DETECT_EN
    ,
    output logic [NUM_FANS-1:0] stall
`endif
);

    localparam int unsigned        WIN_W     = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [SPEED_W-1:0] SPEED_ERR = SPEED_W'(speed_err(SPEED_W));

    logic [WIN_W-1:0]   win_count;
    logic               terminal_c;
    logic               one_hot_c;
    logic [SPEED_W-1:0] sel_speed_c;
    logic [SPEED_W-1:0] speeds [NUM_FANS];

    assign terminal_c = (win_count == WIN_LAST);
    assign one_hot_c  = is_one_hot(MAX_FANS'(fan_selection));

    // Window counter: 0..WINDOW_CYCLES-1, restarts from 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count   <= '0;
            window_done <= 1'b0;
        end else begin
            win_count   <= terminal_c ? '0 : win_count + WIN_W'(1);
            window_done <= terminal_c;
        end
    end

    for (genvar g = 0; g < NUM_FANS; g++) begin : g_chan
        fan_tach_counter #(
            .SPEED_W (SPEED_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tach     (tach[g]),
            .terminal (terminal_c),
            .speed    (speeds[g])
`ifdef FAN_STALL_DETECT_EN
            ,
            .stall    (stall[g])
`endif
        );
    end

    // OR of selected channels; only used when the select is one-hot.
    always_comb begin
        sel_speed_c = '0;
        for (int unsigned i = 0; i < NUM_FANS; i++) begin
            if (fan_selection[i]) begin
                sel_speed_c = sel_speed_c | speeds[i];
            end
        end
    end

    // Read port: one-cycle latency; sel_error holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed_out  <= SPEED_ERR;
            read_valid <= 1'b0;
            sel_error  <= 1'b0;
        end else if (read) begin
            read_valid <= 1'b1;
            if (one_hot_c) begin
                speed_out <= sel_speed_c;
                sel_error <= 1'b0;
            end else begin
                speed_out <= SPEED_ERR;
                sel_error <= 1'b1;
            end
        end else begin
            speed_out  <= SPEED_ERR;
            read_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fan_speed_monitor.sv
`timescale 1ns/1ps
module tb_fan_speed_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (WINDOW_CYCLES=100)
    logic       rst_n;
    logic [3:0] tach;
    logic [3:0] sel;
    logic       read;
    logic [7:0] speed_out;
    logic       read_valid;
    logic       sel_error;
    logic       window_done;

    // Long-window DUT (WINDOW_CYCLES=1000) for the saturation case
    logic       rst_l;
    logic [3:0] tach_l;
    logic [3:0] sel_l;
    logic       read_l;
    logic [7:0] speed_l;
    logic       valid_l;
    logic       err_l;
    logic       wd_l;

`ifdef FAN_STALL_DETECT_EN
    logic [3:0] stall;
    logic [3:0] stall_l;
`endif

    fan_speed_monitor #(
        .NUM_FANS(4), .SPEED_W(8), .WINDOW_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tach(tach), .fan_selection(sel), .read(read),
        .speed_out(speed_out), .read_valid(read_valid), .sel_error(sel_error),
        .window_done(window_done)
`ifdef FAN_STALL_DETECT_EN
        , .stall(stall)
`endif
    );

    fan_speed_monitor #(
        .NUM_FANS(4), .SPEED_W(8), .WINDOW_CYCLES(1000)
    ) dut_long (
        .clk(clk), .rst_n(rst_l), .tach(tach_l), .fan_selection(sel_l), .read(read_l),
        .speed_out(speed_l), .read_valid(valid_l), .sel_error(err_l),
        .window_done(wd_l)
`ifdef FAN_STALL_DETECT_EN
        , .stall(stall_l)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_l_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: main DUT
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n === 1'b1 && read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: speed_out=0x%0h with no read pending", speed_out);
            end else begin
                e = exp_q.pop_front();
                check("read_speed", 32'(speed_out), 32'(e[7:0]));
                check("read_sel_error", 32'(sel_error), 32'(e[8]));
            end
        end
    end

    // Scoreboard monitor: long-window DUT
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_l === 1'b1 && valid_l === 1'b1) begin
            if (exp_l_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_long: speed_out=0x%0h with no read pending", speed_l);
            end else begin
                e = exp_l_q.pop_front();
                check("long_read_speed", 32'(speed_l), 32'(e[7:0]));
                check("long_read_sel_error", 32'(err_l), 32'(e[8]));
            end
        end
    end

    // window_done must pulse exactly every 100 cycles while out of reset
    int last_wd = -1;
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            last_wd = -1;
        end else if (window_done === 1'b1) begin
            if (last_wd >= 0) check("window_period", 32'(cyc - last_wd), 32'd100);
            last_wd = cyc;
        end
    end

    task automatic wait_wd(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (window_done !== 1'b1 && n < 300);
        if (window_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_window_done: timeout after %0d cycles", n);
        end
    endtask

    task automatic wait_wd_l();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wd_l !== 1'b1 && n < 1200);
        if (wd_l !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_window_done_long: timeout after %0d cycles", n);
        end
    endtask

    task automatic do_read(input logic [3:0] s, input logic [7:0] e_speed, input logic e_err);
        sel  = s;
        read = 1'b1;
        exp_q.push_back({e_err, e_speed});
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int ch, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 tach[ch] = 1'b1;
            @(posedge clk); #1 tach[ch] = 1'b0;
        end
    endtask

    task automatic seq_main();
        int n;
        // First window after release must be full length
        wait_wd(n);
        check("first_window_len", 32'(n), 32'd101);

        // 10 pulses on fan1, read right after the next window_done
        pulses(1, 10);
        wait_wd(n);
        do_read(4'b0010, 8'h0A, 1'b0);
        // Back-to-back reads with read held high, bad and good selects
        do_read(4'b0110, 8'hFF, 1'b1);
        do_read(4'b0000, 8'hFF, 1'b1);
        do_read(4'b0001, 8'h00, 1'b0);
        do_read(4'b0010, 8'h0A, 1'b0);
        do_read(4'b0011, 8'hFF, 1'b1);
        read = 1'b0;
        sel  = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        check("idle_read_valid", 32'(read_valid), 32'd0);
        check("idle_speed_out", 32'(speed_out), 32'hFF);
        check("idle_sel_error_hold", 32'(sel_error), 32'd1);

        // Edge detected in the terminal cycle (tach driven in cycle 97)
        wait_wd(n);
        repeat (97) @(posedge clk);
        #1 tach[3] = 1'b1;
        @(posedge clk);
        #1 tach[3] = 1'b0;
        wait_wd(n);
        do_read(4'b1000, 8'h01, 1'b0);
        do_read(4'b0010, 8'h00, 1'b0);
        read = 1'b0;
        wait_wd(n);
        do_read(4'b1000, 8'h00, 1'b0);
        read = 1'b0;

        // Reset mid-window with 5 pulses counted on fan0
        wait_wd(n);
        pulses(0, 5);
        repeat (39) @(posedge clk);
        #1;
        sel  = 4'b0011;
        read = 1'b1;
        exp_q.push_back({1'b1, 8'hFF});
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_speed_out", 32'(speed_out), 32'hFF);
        check("midrst_read_valid", 32'(read_valid), 32'd0);
        check("midrst_sel_error", 32'(sel_error), 32'd0);
        check("midrst_window_done", 32'(window_done), 32'd0);
        read = 1'b0;
        sel  = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midrst_hold_speed_out", 32'(speed_out), 32'hFF);
        check("midrst_hold_window_done", 32'(window_done), 32'd0);
        rst_n = 1'b1;
        wait_wd(n);
        check("post_reset_window_len", 32'(n), 32'd101);
`ifdef FAN_STALL_DETECT_EN
        check("stall_after_1_window", 32'(stall), 32'h0);
`endif
        do_read(4'b0001, 8'h00, 1'b0);
        read = 1'b0;

`ifdef FAN_STALL_DETECT_EN
        wait_wd(n);
        check("stall_after_2_windows", 32'(stall), 32'hF);
        pulses(2, 1);
        wait_wd(n);
        check("stall_cleared_fan2", 32'(stall), 32'hB);
`endif
    endtask

    task automatic seq_long();
        wait_wd_l();
        // 300 pulses in one 1000-cycle window must saturate at 0xFF
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1 tach_l[3] = 1'b1;
            @(posedge clk); #1 tach_l[3] = 1'b0;
        end
        wait_wd_l();
        sel_l  = 4'b1000;
        read_l = 1'b1;
        exp_l_q.push_back({1'b0, 8'hFF});
        @(posedge clk);
        #1;
        sel_l  = 4'b0100;
        exp_l_q.push_back({1'b0, 8'h00});
        @(posedge clk);
        #1;
        read_l = 1'b0;
        sel_l  = 4'b0000;
        @(posedge clk);
        @(posedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rst_l  = 1'b0;
        tach   = 4'b0;
        tach_l = 4'b0;
        sel    = 4'b0011;
        sel_l  = 4'b0;
        read   = 1'b1;
        read_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset values must hold even with a read requested
        check("rst_speed_out", 32'(speed_out), 32'hFF);
        check("rst_read_valid", 32'(read_valid), 32'd0);
        check("rst_sel_error", 32'(sel_error), 32'd0);
        check("rst_window_done", 32'(window_done), 32'd0);
`ifdef FAN_STALL_DETECT_EN
        check("rst_stall", 32'(stall), 32'h0);
`endif
        read  = 1'b0;
        sel   = 4'b0000;
        rst_n = 1'b1;
        rst_l = 1'b1;
        fork
            seq_main();
            seq_long();
        join
        repeat (3) @(posedge clk);
        check("pending_reads", 32'(exp_q.size()), 32'd0);
        check("pending_reads_long", 32'(exp_l_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fan_speed_monitor.md
FAN_SPEED_MONITOR -- requirements
Module: fan_speed_monitor

Interface
REQ-001 The block SHALL have parameter NUM_FANS, default 4, meaning the number of tachometer channels (1..16).
REQ-002 The block SHALL have parameter SPEED_W, default 8, meaning the width of one speed value.
REQ-003 The block SHALL have parameter WINDOW_CYCLES, default 1000000, meaning the measurement window length in clk cycles (minimum 4).
REQ-004 The block SHALL have port clk, input, width 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, width 1, meaning the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port tach, input, width NUM_FANS, meaning the asynchronous tachometer pulse inputs, one bit per fan.
REQ-007 The block SHALL have port fan_selection, input, width NUM_FANS, meaning the one-hot fan select.
REQ-008 The block SHALL have port read, input, width 1, meaning the read request, sampled every cycle.
REQ-009 The block SHALL have port speed_out, output, width SPEED_W, meaning the registered speed readout.
REQ-010 The block SHALL have port read_valid, output, width 1, meaning speed_out carries a valid reading this cycle.
REQ-011 The block SHALL have port sel_error, output, width 1, meaning the last sampled read had a non-one-hot select.
REQ-012 The block SHALL have port window_done, output, width 1, meaning a one-cycle pulse when new speeds are latched.

Function
REQ-013 The block SHALL pass each tach bit through a 2-flop synchroniser, then a rising-edge detector (3 cycles input-to-pulse).
REQ-014 The block SHALL count edge pulses per channel in a SPEED_W counter that saturates at all-ones and never wraps.
REQ-015 The window counter SHALL count 0..WINDOW_CYCLES-1 and wrap to 0; count WINDOW_CYCLES-1 is the terminal cycle.
REQ-016 In the terminal cycle, each latched speed SHALL take the saturated value of count plus that cycle's edge, the count SHALL clear to 0, and window_done SHALL pulse high.
REQ-017 The block SHALL register speed_out, read_valid and sel_error one cycle after read is sampled high, giving a latency of 1.
REQ-018 A read with exactly one selection bit set SHALL return that fan's latched speed with read_valid=1 and sel_error=0.
REQ-019 A read with zero or multiple selection bits set SHALL return all-ones with read_valid=1 and sel_error=1.
REQ-020 A cycle with read low SHALL drive speed_out to all-ones and read_valid to 0 on the next cycle; sel_error SHALL hold its value.
REQ-021 If read is held high, the block SHALL produce a reading every cycle.
REQ-022 A read in the cycle after the terminal cycle SHALL return the new latched value, with no stale mixing across channels.

Reset
REQ-023 While rst_n=0, the block SHALL hold speed_out=all-ones, read_valid=0, sel_error=0, window_done=0, and all counters, latched speeds and synchronisers at 0.
REQ-024 Reset asserted mid-window SHALL discard partial counts; after release, the first window SHALL be a full WINDOW_CYCLES long.

Configuration
REQ-025 With macro FAN_STALL_DETECT_EN defined, the block SHALL add a stall output of width NUM_FANS, reset 0.
REQ-026 Under FAN_STALL_DETECT_EN, stall[i] SHALL set when the latched speed is 0 for 2 consecutive windows, and SHALL clear at the first window with a non-zero latched speed.
REQ-027 Without FAN_STALL_DETECT_EN, the block SHALL have no stall port and no stall logic.

Structure
REQ-028 Package fan_pkg SHALL hold SPEED_ERR (all-ones pattern function of SPEED_W), the stall window count constant 2, and the one-hot check function.
REQ-029 Sub-module fan_tach_counter SHALL implement one channel (synchroniser, edge detect, saturating counter, latch), instanced NUM_FANS times via generate.

Verification (bench: NUM_FANS=4, SPEED_W=8, WINDOW_CYCLES=100)
REQ-030 Scenario: 10 tach pulses on fan1 in one window, then read with select 4'b0010 -> speed_out=0x0A, read_valid=1, sel_error=0, one cycle after read.
REQ-031 Scenario: 300 pulses on fan3 within one window (WINDOW_CYCLES=1000 run) -> latched 0xFF, no wrap.
REQ-032 Scenario: select 4'b0110, then 4'b0000 -> speed_out=0xFF, sel_error=1 both times; select 4'b0001 next -> sel_error=0.
REQ-033 Scenario: pulse edge detected exactly in the terminal cycle -> counted in the current window; window_done high exactly every 100 cycles.
REQ-034 Scenario: rst_n dropped at cycle 50 of a window with 5 pulses counted -> outputs reach reset values immediately; the next latched value excludes the 5 pulses.
REQ-035 Scenario (FAN_STALL_DETECT_EN): fan2 idle for 2 windows -> stall[2]=1; 1 pulse in the next window -> stall[2]=0 at that window_done.
